// File: rtl/udp_tx_packer.sv
// Byte-stream to UDP payload packer: buffers input bytes in a FIFO and hands
// packets of up to MAX_PAYLOAD bytes to the stack's request/ack/data interface.
module udp_tx_packer #(
  parameter int FIFO_DEPTH     = 2048,
  parameter int MAX_PAYLOAD    = 1024,
  parameter int TIMEOUT_CYCLES = 12500,
  parameter int GAP_CYCLES     = 4
) (
  input  logic        udp_clk,
  input  logic        rstn,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  input  logic        flush,
  input  logic        udp_tx_ready,
  input  logic        app_tx_ack,
  output logic        app_tx_data_request,
  output logic        app_tx_data_valid,
  output logic [7:0]  app_tx_data,
  output logic [15:0] udp_data_length,
  output logic        busy,
  output logic [15:0] pkt_cnt
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [AW:0]   FULL  = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]   MAXP  = (AW+1)'(MAX_PAYLOAD);
  localparam logic [TW-1:0] TMAX  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [GW-1:0] GLAST = GW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, REQ, SEND, GAP} state_t;

  state_t        state_q;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   fill_q, fill_d;
  logic [TW-1:0] timer_q;
  logic [GW-1:0] gap_q;
  logic [15:0]   remaining_q, len_d, len_q, pkt_cnt_q;
  logic [7:0]    data_q;
  logic          req_q, valid_q, flush_pend_q;
  logic          wr, rd, launch;

  assign in_ready = (fill_q != FULL);
  assign wr       = in_valid && in_ready;
  // Launch only ever takes len <= fill bytes, so reads can never underflow.
  assign rd       = (state_q == REQ && app_tx_ack) ||
                    (state_q == SEND && remaining_q > 16'd1);
  assign launch   = (state_q == IDLE) && udp_tx_ready && (fill_q != '0) &&
                    (fill_q >= MAXP || timer_q == TMAX || flush_pend_q || flush);
  assign len_d    = (fill_q >= MAXP) ? 16'(MAXP) : 16'(fill_q);

  assign app_tx_data_request = req_q;
  assign app_tx_data_valid   = valid_q;
  assign app_tx_data         = data_q;
  assign udp_data_length     = len_q;
  assign busy                = (state_q != IDLE);
  assign pkt_cnt             = pkt_cnt_q;

  always_comb begin
    fill_d = fill_q;
    if (wr && !rd)      fill_d = fill_q + (AW+1)'(1);
    else if (rd && !wr) fill_d = fill_q - (AW+1)'(1);
  end

  always_ff @(posedge udp_clk) begin
    if (wr) mem[wr_ptr_q] <= in_data;
  end

  always_ff @(posedge udp_clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      if (wr) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd) rd_ptr_q <= rd_ptr_q + AW'(1);
      fill_q <= fill_d;
    end
  end

  always_ff @(posedge udp_clk or negedge rstn) begin
    if (!rstn) begin
      timer_q      <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      if (launch || state_q != IDLE || fill_q == '0) timer_q <= '0;
      else if (timer_q != TMAX)                      timer_q <= timer_q + TW'(1);
      // A flush against an empty buffer is dropped rather than held.
      if (launch)     flush_pend_q <= 1'b0;
      else if (flush) flush_pend_q <= (fill_q != '0);
    end
  end

  always_ff @(posedge udp_clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      req_q       <= 1'b0;
      valid_q     <= 1'b0;
      data_q      <= '0;
      len_q       <= '0;
      remaining_q <= '0;
      gap_q       <= '0;
      pkt_cnt_q   <= '0;
    end else begin
      if (rd) data_q <= mem[rd_ptr_q];
      case (state_q)
        IDLE: if (launch) begin
          len_q   <= len_d;
          req_q   <= 1'b1;
          state_q <= REQ;
        end
        REQ: if (app_tx_ack) begin
          req_q       <= 1'b0;
          valid_q     <= 1'b1;
          remaining_q <= len_q;
          state_q     <= SEND;
        end
        SEND: if (remaining_q == 16'd1) begin
          valid_q   <= 1'b0;
          pkt_cnt_q <= pkt_cnt_q + 16'd1;
          gap_q     <= '0;
          state_q   <= GAP;
        end else begin
          remaining_q <= remaining_q - 16'd1;
        end
        GAP: if (gap_q == GLAST) state_q <= IDLE;
             else gap_q <= gap_q + GW'(1);
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_udp_tx_packer.sv
// Scoreboard bench for udp_tx_packer: written bytes and hand-computed packet
// lengths are queued, a negedge monitor pops and compares them against the DUT.
module tb_udp_tx_packer;
  localparam int GAP = 4;
  localparam int TMO = 12500;

  logic        udp_clk = 1'b0, rstn = 1'b0;
  logic        in_valid = 1'b0, flush = 1'b0, udp_tx_ready = 1'b0, app_tx_ack = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_ready, app_tx_data_request, app_tx_data_valid, busy;
  logic [7:0]  app_tx_data;
  logic [15:0] udp_data_length, pkt_cnt;

  udp_tx_packer dut (
    .udp_clk(udp_clk), .rstn(rstn), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .flush(flush), .udp_tx_ready(udp_tx_ready),
    .app_tx_ack(app_tx_ack), .app_tx_data_request(app_tx_data_request),
    .app_tx_data_valid(app_tx_data_valid), .app_tx_data(app_tx_data),
    .udp_data_length(udp_data_length), .busy(busy), .pkt_cnt(pkt_cnt)
  );

  always #4 udp_clk = ~udp_clk;

  int cyc = 0;
  always @(posedge udp_clk) cyc <= cyc + 1;

  int n_chk = 0, n_fail = 0;
  logic [7:0] exp_q[$];
  int         exp_len[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor / scoreboard
  logic prev_req = 0, prev_valid = 0, prev_ack = 0, seen_pkt = 0;
  int   run_len = 0, gap_len = 0, cur_len = 0, exp_pkt = 0, req_cyc = 0;

  always @(negedge udp_clk) begin
    if (!rstn) begin
      exp_q.delete();
      exp_len.delete();
      prev_req = 0; prev_valid = 0; prev_ack = 0; seen_pkt = 0;
      run_len = 0; gap_len = 0; exp_pkt = 0;
    end else begin
      if (in_valid && in_ready) exp_q.push_back(in_data);
      if (app_tx_data_request && !prev_req) begin
        req_cyc = cyc;
        cur_len = int'(udp_data_length);
        if (exp_len.size() == 0) chk("unexpected_request", 1, 0);
        else chk("udp_data_length", udp_data_length, exp_len.pop_front());
        if (seen_pkt) chk("inter_packet_gap_ok", gap_len >= GAP, 1);
      end
      if (prev_ack) chk("valid_after_ack", app_tx_data_valid, 1);
      if (app_tx_data_valid) begin
        run_len++;
        if (exp_q.size() == 0) chk("unexpected_byte", 1, 0);
        else chk("payload_byte", app_tx_data, exp_q.pop_front());
      end else if (prev_valid) begin
        chk("valid_run_len", run_len, cur_len);
        exp_pkt++;
        chk("pkt_cnt_after_pkt", pkt_cnt, exp_pkt & 16'hFFFF);
        run_len = 0; gap_len = 0; seen_pkt = 1;
      end
      if (!app_tx_data_valid && !app_tx_data_request) gap_len++;
      prev_req   = app_tx_data_request;
      prev_valid = app_tx_data_valid;
      prev_ack   = app_tx_ack;
    end
  end

  // Stack model: ack three cycles after the request is seen
  initial forever begin
    @(negedge udp_clk);
    if (rstn && app_tx_data_request) begin
      repeat (3) @(posedge udp_clk);
      #1 app_tx_ack = 1'b1;
      @(posedge udp_clk);
      #1 app_tx_ack = 1'b0;
    end
  end

  task automatic wr_bytes(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      int g;
      g = 0;
      in_valid = 1'b1;
      in_data  = 8'(base + i);
      @(negedge udp_clk);
      while (!in_ready && g < 5000) begin
        @(negedge udp_clk);
        g++;
      end
      @(posedge udp_clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    @(posedge udp_clk); #1;
    flush = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    bit done;
    done = 0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge udp_clk);
      done = (exp_len.size() == 0 && exp_q.size() == 0 && !busy);
    end
    chk("drain_done", done, 1);
    @(posedge udp_clk); #1;
  endtask

  initial begin
    int  n0;
    bit  got;
    repeat (3) @(posedge udp_clk); #1;
    chk("rst_request", app_tx_data_request, 0);
    chk("rst_valid", app_tx_data_valid, 0);
    chk("rst_data", app_tx_data, 0);
    chk("rst_length", udp_data_length, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pkt_cnt", pkt_cnt, 0);
    chk("rst_in_ready", in_ready, 1);
    rstn = 1'b1;
    udp_tx_ready = 1'b1;
    @(posedge udp_clk); #1;

    // Full-size packet
    exp_len.push_back(1024);
    wr_bytes(1024, 0);
    wait_idle(3000);
    chk("pkt_cnt_full", pkt_cnt, 1);

    // Explicit flush of a short buffer
    exp_len.push_back(5);
    wr_bytes(5, 8'h40);
    pulse_flush();
    chk("req_after_flush", app_tx_data_request, 1);
    wait_idle(200);
    chk("pkt_cnt_flush", pkt_cnt, 2);

    // Flush with nothing buffered is ignored
    pulse_flush();
    chk("flush_pend_empty", dut.flush_pend_q, 0);
    chk("no_req_empty_flush", app_tx_data_request, 0);

    // Idle timeout on a 10-byte buffer
    exp_len.push_back(10);
    n0 = cyc;
    wr_bytes(1, 8'h80);
    repeat (10) @(posedge udp_clk);
    #1;
    chk("no_req_before_timeout", app_tx_data_request, 0);
    chk("idle_before_timeout", busy, 0);
    wr_bytes(9, 8'h81);
    wait_idle(TMO + 500);
    chk("timeout_latency", req_cyc, n0 + 1 + TMO);
    chk("pkt_cnt_timeout", pkt_cnt, 3);

    // Fill the whole buffer while the stack is not ready
    udp_tx_ready = 1'b0;
    wr_bytes(2048, 3);
    chk("in_ready_full", in_ready, 0);
    in_valid = 1'b1;
    in_data  = 8'hEE;
    repeat (2) @(posedge udp_clk);
    #1;
    in_valid = 1'b0;
    chk("in_ready_still_full", in_ready, 0);
    chk("no_launch_not_ready", busy, 0);
    exp_len.push_back(1024);
    exp_len.push_back(1024);
    udp_tx_ready = 1'b1;
    wait_idle(5000);
    chk("pkt_cnt_two_pkts", pkt_cnt, 5);

    // Continuous input streaming across eight packets
    for (int k = 0; k < 8; k++) exp_len.push_back(1024);
    wr_bytes(8192, 8'h11);
    wait_idle(12000);
    chk("pkt_cnt_stream", pkt_cnt, 13);

    // Reset in the middle of a payload
    exp_len.push_back(20);
    wr_bytes(20, 8'hC0);
    pulse_flush();
    got = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(posedge udp_clk); #1;
      got = app_tx_data_valid;
    end
    chk("valid_before_reset", got, 1);
    repeat (5) @(posedge udp_clk);
    #1;
    rstn = 1'b0;
    #1;
    chk("midrst_request", app_tx_data_request, 0);
    chk("midrst_valid", app_tx_data_valid, 0);
    chk("midrst_data", app_tx_data, 0);
    chk("midrst_length", udp_data_length, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_pkt_cnt", pkt_cnt, 0);
    chk("midrst_in_ready", in_ready, 1);
    repeat (3) @(posedge udp_clk);
    #1;
    rstn = 1'b1;
    @(posedge udp_clk); #1;
    exp_len.push_back(3);
    wr_bytes(3, 8'hA5);
    pulse_flush();
    chk("req_after_reset_flush", app_tx_data_request, 1);
    wait_idle(200);
    chk("pkt_cnt_after_reset", pkt_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
